// File: rtl/ldpc_3gpp_dec_source_pkg.sv
// Shared types and constants for the 3GPP LDPC decoder input side: code context,
// the lifting-size table and the systematic column count per base graph.
package ldpc_3gpp_dec_source_pkg;

  localparam int cCOL_BY_CYCLE = 4;

  typedef logic [8:0] hb_zc_t;
  typedef logic [6:0] hb_col_t;

  typedef struct packed {
    logic       idxGr;
    logic [2:0] idxLs;
    logic [2:0] idxZc;
    logic [5:0] used_row;
  } code_ctx_t;

  // Rows are lifting-size sets; short sets repeat their largest Zc in the unused slots.
  localparam hb_zc_t cZC_TAB [8][8] = '{
    '{9'd2,  9'd4,  9'd8,  9'd16,  9'd32,  9'd64,  9'd128, 9'd256},
    '{9'd3,  9'd6,  9'd12, 9'd24,  9'd48,  9'd96,  9'd192, 9'd384},
    '{9'd5,  9'd10, 9'd20, 9'd40,  9'd80,  9'd160, 9'd320, 9'd320},
    '{9'd7,  9'd14, 9'd28, 9'd56,  9'd112, 9'd224, 9'd224, 9'd224},
    '{9'd9,  9'd18, 9'd36, 9'd72,  9'd144, 9'd288, 9'd288, 9'd288},
    '{9'd11, 9'd22, 9'd44, 9'd88,  9'd176, 9'd352, 9'd352, 9'd352},
    '{9'd13, 9'd26, 9'd52, 9'd104, 9'd208, 9'd208, 9'd208, 9'd208},
    '{9'd15, 9'd30, 9'd60, 9'd120, 9'd240, 9'd240, 9'd240, 9'd240}
  };

  localparam hb_col_t cGR_SYST_BIT_COL [2] = '{7'd22, 7'd10};

  // Index width for a counter holding values 0..v-1 (never narrower than one bit).
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/ldpc_3gpp_dec_source.sv
// Decoder input interface: writes a framed LLR stream into the input buffer using the
// same word/lane layout as the output sink, then pulses owfull with tag and length status.
module ldpc_3gpp_dec_source
  import ldpc_3gpp_dec_source_pkg::*;
#(
  parameter int pADDR_W  = 8,
  parameter int pLLR_W   = 5,
  parameter int pDAT_NUM = cCOL_BY_CYCLE,
  parameter int pTAG_W   = 4,
  parameter int pIDX_GR  = 0
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  code_ctx_t           icode_ctx,
  input  logic                isop,
  input  logic                ieop,
  input  logic                ival,
  input  logic [pLLR_W-1:0]   idat,
  input  logic [pTAG_W-1:0]   itag,
  output logic                ordy,
  input  logic                iwfull,
  output logic                owrite,
  output logic [pADDR_W-1:0]  owaddr,
  output logic [pDAT_NUM-1:0] owsel,
  output logic [pLLR_W-1:0]   owdat,
  output logic                owfull,
  output logic [pTAG_W-1:0]   owtag,
  output logic                oerr
);

  localparam int cCIB    = ceil_div(int'(cGR_SYST_BIT_COL[pIDX_GR]), pDAT_NUM);
  localparam int cBCOL_W = clogb2(cCIB);
  localparam int cBSEL_W = clogb2(pDAT_NUM);
  localparam logic [cBCOL_W-1:0] cBCOL_LAST = cBCOL_W'(cCIB - 1);
  localparam logic [cBSEL_W-1:0] cBSEL_LAST = cBSEL_W'(pDAT_NUM - 1);
  localparam logic               cBCOL_ONE  = (cCIB == 1);
  localparam logic [pDAT_NUM-1:0] cLANE0    = pDAT_NUM'(1);

  typedef enum logic [1:0] {cWAIT_SOP, cDO, cFLUSH} state_t;

  // Handshake: a beat transfers on a clock edge where ival & ordy & iclkena are all high;
  // ordy never depends on ival, and all state (including outputs) holds while iclkena is low.

  state_t                state_q, state_d;
  logic                  flush_cnt_q, flush_cnt_d;
  hb_zc_t                used_zc_q, used_zc_d;
  hb_col_t               used_col_q, used_col_d;
  hb_zc_t                zc_cnt_q, zc_cnt_d;
  logic                  zc_done_q, zc_done_d;
  hb_col_t               col_cnt_q, col_cnt_d;
  logic                  col_done_q, col_done_d;
  logic [cBCOL_W-1:0]    bcol_cnt_q, bcol_cnt_d;
  logic                  bcol_done_q, bcol_done_d;
  logic [cBSEL_W-1:0]    bsel_q, bsel_d;
  logic [pADDR_W-1:0]    addr_q, addr_d;
  logic [pTAG_W-1:0]     tag_q, tag_d;
  logic                  err_q, err_d;
  logic                  owrite_q, owrite_d;
  logic [pADDR_W-1:0]    owaddr_q, owaddr_d;
  logic [pDAT_NUM-1:0]   owsel_q, owsel_d;
  logic [pLLR_W-1:0]     owdat_q, owdat_d;
  logic                  owfull_q, owfull_d;
  logic [pTAG_W-1:0]     owtag_q, owtag_d;
  logic                  oerr_q, oerr_d;

  logic                  accept, sop_beat, in_frame, beat, last, work_done;
  hb_zc_t                new_zc, cur_zc, e_zc;
  hb_col_t               new_col, cur_col, e_col;
  logic [cBCOL_W-1:0]    e_bcol;
  logic [cBSEL_W-1:0]    e_bsel;
  logic [pADDR_W-1:0]    e_addr;
  logic                  e_zc_done, e_col_done, e_bcol_done;

  assign ordy = ~ireset & (((state_q == cWAIT_SOP) & ~iwfull) | (state_q == cDO));

  // The sop beat itself sits at position zero, so counters are muxed to their cleared
  // values (done flags derived from the new context) rather than waiting a cycle.
  always_comb begin
    accept      = ival & ordy & iclkena;
    sop_beat    = accept & isop;
    in_frame    = (state_q == cDO) | sop_beat;
    beat        = accept & in_frame;
    new_zc      = cZC_TAB[icode_ctx.idxLs][icode_ctx.idxZc];
    new_col     = cGR_SYST_BIT_COL[icode_ctx.idxGr] + hb_col_t'(icode_ctx.used_row);
    cur_zc      = sop_beat ? new_zc  : used_zc_q;
    cur_col     = sop_beat ? new_col : used_col_q;
    e_zc        = sop_beat ? '0 : zc_cnt_q;
    e_col       = sop_beat ? '0 : col_cnt_q;
    e_bcol      = sop_beat ? '0 : bcol_cnt_q;
    e_bsel      = sop_beat ? '0 : bsel_q;
    e_addr      = sop_beat ? '0 : addr_q;
    e_zc_done   = sop_beat ? (new_zc == hb_zc_t'(1))   : zc_done_q;
    e_col_done  = sop_beat ? (new_col == hb_col_t'(1)) : col_done_q;
    e_bcol_done = sop_beat ? cBCOL_ONE : bcol_done_q;
    work_done   = e_zc_done & e_col_done;
    last        = beat & (ieop | work_done);
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    used_zc_d   = used_zc_q;
    used_col_d  = used_col_q;
    zc_cnt_d    = zc_cnt_q;
    zc_done_d   = zc_done_q;
    col_cnt_d   = col_cnt_q;
    col_done_d  = col_done_q;
    bcol_cnt_d  = bcol_cnt_q;
    bcol_done_d = bcol_done_q;
    bsel_d      = bsel_q;
    addr_d      = addr_q;
    tag_d       = sop_beat ? itag : tag_q;
    err_d       = err_q;
    owrite_d    = 1'b0;
    owaddr_d    = owaddr_q;
    owsel_d     = '0;
    owdat_d     = owdat_q;
    owfull_d    = 1'b0;
    owtag_d     = owtag_q;
    oerr_d      = oerr_q;

    if (beat) begin
      used_zc_d   = cur_zc;
      used_col_d  = cur_col;
      col_cnt_d   = e_col;
      col_done_d  = e_col_done;
      bcol_cnt_d  = e_bcol;
      bcol_done_d = e_bcol_done;
      bsel_d      = e_bsel;
      addr_d      = e_addr + pADDR_W'(1);
      if (e_zc_done) begin
        zc_cnt_d  = '0;
        zc_done_d = (cur_zc == hb_zc_t'(1));
        if (e_col_done) begin
          col_cnt_d  = '0;
          col_done_d = (cur_col == hb_col_t'(1));
        end else begin
          col_cnt_d  = e_col + hb_col_t'(1);
          col_done_d = ((e_col + hb_col_t'(1)) == (cur_col - hb_col_t'(1)));
        end
        // Finishing a block of columns moves to the next lane and restarts the word address.
        if (e_bcol_done) begin
          bcol_cnt_d  = '0;
          bcol_done_d = cBCOL_ONE;
          addr_d      = '0;
          bsel_d      = (e_bsel == cBSEL_LAST) ? '0 : e_bsel + cBSEL_W'(1);
        end else begin
          bcol_cnt_d  = e_bcol + cBCOL_W'(1);
          bcol_done_d = ((e_bcol + cBCOL_W'(1)) == cBCOL_LAST);
        end
      end else begin
        zc_cnt_d  = e_zc + hb_zc_t'(1);
        zc_done_d = ((e_zc + hb_zc_t'(1)) == (cur_zc - hb_zc_t'(1)));
      end
      owrite_d = 1'b1;
      owaddr_d = e_addr;
      owsel_d  = cLANE0 << e_bsel;
      owdat_d  = idat;
      if (last) err_d = ieop ^ work_done;
    end

    case (state_q)
      cWAIT_SOP: if (sop_beat) state_d = last ? cFLUSH : cDO;
      cDO:       if (last) state_d = cFLUSH;
      cFLUSH: begin
        if (flush_cnt_q) begin
          state_d     = cWAIT_SOP;
          flush_cnt_d = 1'b0;
        end else begin
          flush_cnt_d = 1'b1;
          owfull_d    = 1'b1;
          owtag_d     = tag_q;
          oerr_d      = err_q;
        end
      end
      default:   state_d = cWAIT_SOP;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q     <= cWAIT_SOP;
      flush_cnt_q <= 1'b0;
      used_zc_q   <= '0;
      used_col_q  <= '0;
      zc_cnt_q    <= '0;
      zc_done_q   <= 1'b0;
      col_cnt_q   <= '0;
      col_done_q  <= 1'b0;
      bcol_cnt_q  <= '0;
      bcol_done_q <= 1'b0;
      bsel_q      <= '0;
      addr_q      <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      owrite_q    <= 1'b0;
      owaddr_q    <= '0;
      owsel_q     <= '0;
      owdat_q     <= '0;
      owfull_q    <= 1'b0;
      owtag_q     <= '0;
      oerr_q      <= 1'b0;
    end else if (iclkena) begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      used_zc_q   <= used_zc_d;
      used_col_q  <= used_col_d;
      zc_cnt_q    <= zc_cnt_d;
      zc_done_q   <= zc_done_d;
      col_cnt_q   <= col_cnt_d;
      col_done_q  <= col_done_d;
      bcol_cnt_q  <= bcol_cnt_d;
      bcol_done_q <= bcol_done_d;
      bsel_q      <= bsel_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      owrite_q    <= owrite_d;
      owaddr_q    <= owaddr_d;
      owsel_q     <= owsel_d;
      owdat_q     <= owdat_d;
      owfull_q    <= owfull_d;
      owtag_q     <= owtag_d;
      oerr_q      <= oerr_d;
    end
  end

  assign owrite = owrite_q;
  assign owaddr = owaddr_q;
  assign owsel  = owsel_q;
  assign owdat  = owdat_q;
  assign owfull = owfull_q;
  assign owtag  = owtag_q;
  assign oerr   = oerr_q;

endmodule
